uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//   UART receive framer; consumer of the rx bit-rate generator's mid-bit pulse (bps_tick).
//   Detects start bit, samples each bit once per bps_tick, checks stop/parity, delivers byte.
//   Drives bps_en so the generator counts only during a frame, aligning ticks to bit centres.
// PARAMETERS
//   DATA_BITS   8  data bits per frame, LSB first (legal 5..8)
//   PARITY_EN   0  1 = one parity bit between last data bit and stop bit
//   PARITY_ODD  0  1 = odd parity, 0 = even (ignored when PARITY_EN=0)
// PORTS
//   clk        in   1          system clock (2.4576 MHz)
//   reset      in   1          asynchronous, active-high
//   rx         in   1          serial line, asynchronous, idle high
//   bps_tick   in   1          1-clk pulse at bit centre from bit-rate generator
//   bps_en     out  1          high while a frame is in progress; generator held cleared when low
//   rx_data    out  DATA_BITS  last received byte, held until next frame completes
//   rx_valid   out  1          1-clk pulse: rx_data updated
//   frame_err  out  1          1-clk pulse with rx_valid: stop bit sampled 0
//   parity_err out  1          1-clk pulse with rx_valid: parity mismatch (0 if PARITY_EN=0)
//   busy       out  1          high in any state other than IDLE
// BEHAVIOUR
//   Reset values: bps_en=0, rx_data=0, rx_valid=0, frame_err=0, parity_err=0, busy=0, state=IDLE.
//   rx passes a 2-FF synchroniser (flops reset to 1); rx_s = 2nd stage, rx_d = rx_s delayed 1 clk.
//   Falling edge = rx_d==1 && rx_s==0. All sampling uses rx_s.
//   States: IDLE, START, DATA, PARITY, STOP.
//   IDLE: on falling edge -> START, bps_en=1 from next cycle. bps_tick ignored in IDLE.
//   START: at bps_tick: rx_s==0 -> DATA, bit_cnt=0; rx_s==1 -> IDLE (false start, no outputs).
//   DATA: at bps_tick shift rx_s into shift reg MSB, shift right; bit_cnt++;
//     after DATA_BITS-th tick -> PARITY if PARITY_EN else STOP.
//   PARITY: at bps_tick capture parity bit -> STOP.
//     parity_err = (^data ^ pbit) != PARITY_ODD.
//   STOP: at bps_tick -> IDLE; next cycle rx_valid=1, rx_data=shift reg,
//     frame_err=~rx_s(stop), parity_err per above. All three are single-cycle.
//   Latency: rx_valid one clk after the stop-bit tick.
//   bps_en drops in the same cycle state returns to IDLE (no extra tick consumed).
//   Byte is delivered even on frame/parity error; errors only flag it.
//   Break / stop=0: return to IDLE; no new frame until line seen high then low (edge, not level).
//   Back-to-back frames: start edge accepted in first IDLE cycle after STOP; no dead time beyond that.
//   bps_tick outside a frame or a tick coincident with IDLE->START entry is ignored.
//   Async reset mid-frame: all state/outputs to reset values immediately; partial byte discarded.
//   No bus/stall handshake: rx_valid is a strobe, consumer must take rx_data same cycle or later
//     before next rx_valid (≥1 frame time).
// TESTING  (bench generator: bps_tick period 128 clk, first tick 65 clk after bps_en rises; 8N1 unless noted)
//   Send 0xA5, valid stop -> one rx_valid pulse, rx_data=0xA5, frame_err=0, busy low after.
//   rx low for 10 clk then high -> START entered, START tick sees 1 -> IDLE, no rx_valid, bps_en=0.
//   Send 0x3C with stop=0, line held low 3 bit times -> rx_data=0x3C, frame_err=1; no second frame until rise+fall.
//   PARITY_EN=1 even: 0x07 with parity 1 -> parity_err=0; 0x07 with parity 0 -> parity_err=1.
//   Assert reset during bit 4 of 0x81 -> outputs 0 at once; then send 0x5A -> rx_data=0x5A, no errors.
//   Back-to-back 0x00,0xFF, zero idle between -> two rx_valid pulses, data 0x00 then 0xFF.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
// Signal bundle between the UART receive framer, its bit-rate generator and the byte consumer.
// slave = the framer itself; master = the environment around it.
interface uart_rx_ctrl_if #(
  parameter int DATA_BITS = 8
);
  logic                 rx;
  logic                 bps_tick;
  logic                 bps_en;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 parity_err;
  logic                 busy;
  logic [2:0]           state_dbg;

  modport slave (
    input  rx, bps_tick,
    output bps_en, rx_data, rx_valid, frame_err, parity_err, busy, state_dbg
  );

  modport master (
    output rx, bps_tick,
    input  bps_en, rx_data, rx_valid, frame_err, parity_err, busy, state_dbg
  );
endinterface

// File: rtl/uart_rx_ctrl.sv
// UART receive framer: finds the start edge, samples one bit per bps_tick at bit centre,
// checks parity/stop and strobes the byte out; bps_en gates the bit-rate generator.
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0
) (
  input  logic           clk,
  input  logic           reset,
  uart_rx_ctrl_if.slave  u
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  localparam logic       PAR_EN   = (PARITY_EN != 0);
  localparam logic       PAR_ODD  = (PARITY_ODD != 0);
  localparam logic [3:0] LAST_BIT = 4'(DATA_BITS - 1);

  state_t               state_q, state_d;
  logic                 rx_meta_q, rx_meta_d;
  logic                 rx_s_q, rx_s_d;
  logic                 rx_d_q, rx_d_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 pbit_q, pbit_d;
  logic [DATA_BITS-1:0] rx_data_q, rx_data_d;
  logic                 rx_valid_q, rx_valid_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_q, parity_err_d;
  logic                 fall;

  // Edge (not level) detection means a held-low break cannot retrigger a frame.
  assign fall = rx_d_q & ~rx_s_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q    <= 1'b1;
      rx_s_q       <= 1'b1;
      rx_d_q       <= 1'b1;
      state_q      <= S_IDLE;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      pbit_q       <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      frame_err_q  <= 1'b0;
      parity_err_q <= 1'b0;
    end else begin
      rx_meta_q    <= rx_meta_d;
      rx_s_q       <= rx_s_d;
      rx_d_q       <= rx_d_d;
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      pbit_q       <= pbit_d;
      rx_data_q    <= rx_data_d;
      rx_valid_q   <= rx_valid_d;
      frame_err_q  <= frame_err_d;
      parity_err_q <= parity_err_d;
    end
  end

  always_comb begin
    rx_meta_d    = u.rx;
    rx_s_d       = rx_meta_q;
    rx_d_d       = rx_s_q;
    state_d      = state_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    pbit_d       = pbit_q;
    rx_data_d    = rx_data_q;
    rx_valid_d   = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (fall) state_d = S_START;
      end
      S_START: begin
        if (u.bps_tick) begin
          if (!rx_s_q) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_DATA: begin
        if (u.bps_tick) begin
          // LSB arrives first, so shifting right leaves it at bit 0 after the last bit.
          shift_d   = {rx_s_q, shift_q[DATA_BITS-1:1]};
          bit_cnt_d = bit_cnt_q + 4'd1;
          if (bit_cnt_q == LAST_BIT) state_d = PAR_EN ? S_PARITY : S_STOP;
        end
      end
      S_PARITY: begin
        if (u.bps_tick) begin
          pbit_d  = rx_s_q;
          state_d = S_STOP;
        end
      end
      S_STOP: begin
        if (u.bps_tick) begin
          state_d      = S_IDLE;
          rx_valid_d   = 1'b1;
          rx_data_d    = shift_q;
          frame_err_d  = ~rx_s_q;
          parity_err_d = PAR_EN & ((^shift_q ^ pbit_q) != PAR_ODD);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // rx_valid is a one-cycle strobe with no ready: rx_data holds until the next strobe,
  // and frame_err/parity_err are meaningful only in the strobe cycle.
  assign u.bps_en     = (state_q != S_IDLE);
  assign u.busy       = (state_q != S_IDLE);
  assign u.state_dbg  = state_q;
  assign u.rx_data    = rx_data_q;
  assign u.rx_valid   = rx_valid_q;
  assign u.frame_err  = frame_err_q;
  assign u.parity_err = parity_err_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Bench for uart_rx_ctrl: an 8N1 and an 8E1 instance, each fed by a model bit-rate generator,
// with a queue-based scoreboard checking every rx_valid strobe.
module tb_uart_rx_ctrl;

  localparam int BIT = 128;

  logic clk;
  logic reset;

  uart_rx_ctrl_if #(.DATA_BITS(8)) if0 ();
  uart_rx_ctrl_if #(.DATA_BITS(8)) if1 ();

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(0), .PARITY_ODD(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .u     (if0)
  );

  uart_rx_ctrl #(.DATA_BITS(8), .PARITY_EN(1), .PARITY_ODD(0)) dut1 (
    .clk   (clk),
    .reset (reset),
    .u     (if1)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bit-rate generator model: cleared while bps_en is low, first tick 65 clk after it rises.
  logic [6:0] gcnt0, gcnt1;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      gcnt0 <= '0;
      gcnt1 <= '0;
    end else begin
      gcnt0 <= if0.bps_en ? gcnt0 + 7'd1 : 7'd0;
      gcnt1 <= if1.bps_en ? gcnt1 + 7'd1 : 7'd0;
    end
  end
  assign if0.bps_tick = if0.bps_en && (gcnt0 == 7'd64);
  assign if1.bps_tick = if1.bps_en && (gcnt1 == 7'd64);

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [9:0] exp_q0[$];
  logic [9:0] exp_q1[$];
  logic [9:0] e0, e1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic flag_fail(input string name, input logic [31:0] act);
    n_checks++;
    n_fail++;
    $display("FAIL %s actual=%0h required=none at %0t", name, act, $time);
  endtask

  always @(negedge clk) begin
    if (if0.rx_valid) begin
      if (exp_q0.size() == 0) flag_fail("unexpected_rx_valid0", 32'(if0.rx_data));
      else begin
        e0 = exp_q0.pop_front();
        check("rx_data0", 32'(if0.rx_data), 32'(e0[7:0]));
        check("frame_err0", 32'(if0.frame_err), 32'(e0[8]));
        check("parity_err0", 32'(if0.parity_err), 32'(e0[9]));
      end
    end else if (if0.frame_err || if0.parity_err) begin
      flag_fail("stray_err_flag0", {30'd0, if0.parity_err, if0.frame_err});
    end
  end

  always @(negedge clk) begin
    if (if1.rx_valid) begin
      if (exp_q1.size() == 0) flag_fail("unexpected_rx_valid1", 32'(if1.rx_data));
      else begin
        e1 = exp_q1.pop_front();
        check("rx_data1", 32'(if1.rx_data), 32'(e1[7:0]));
        check("frame_err1", 32'(if1.frame_err), 32'(e1[8]));
        check("parity_err1", 32'(if1.parity_err), 32'(e1[9]));
      end
    end else if (if1.frame_err || if1.parity_err) begin
      flag_fail("stray_err_flag1", {30'd0, if1.parity_err, if1.frame_err});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_rx(input int sel, input logic b);
    if (sel == 0) if0.rx = b;
    else          if1.rx = b;
  endtask

  task automatic hold(input int sel, input logic b, input int clks);
    set_rx(sel, b);
    repeat (clks) @(negedge clk);
  endtask

  // Reference: byte as sent, frame error when stop bit is 0, and on the parity
  // instance an error when the count of ones over data+parity is odd (even parity).
  task automatic push_exp(input int sel, input logic [7:0] data, input logic stop, input logic pbit);
    logic perr;
    perr = (sel == 1) ? (($countones({data, pbit}) % 2) != 0) : 1'b0;
    if (sel == 0) exp_q0.push_back({perr, ~stop, data});
    else          exp_q1.push_back({perr, ~stop, data});
  endtask

  task automatic send_frame(input int sel, input logic [7:0] data, input logic stop,
                            input logic pbit, input int gap);
    push_exp(sel, data, stop, pbit);
    hold(sel, 1'b0, BIT);
    for (int i = 0; i < 8; i++) hold(sel, data[i], BIT);
    if (sel == 1) hold(sel, pbit, BIT);
    hold(sel, stop, BIT);
    if (gap > 0) hold(sel, 1'b1, gap);
  endtask

  task automatic wait_drain(input int sel);
    int left;
    left = (sel == 0) ? exp_q0.size() : exp_q1.size();
    for (int i = 0; i < 4000 && left != 0; i++) begin
      @(negedge clk);
      left = (sel == 0) ? exp_q0.size() : exp_q1.size();
    end
    check(sel == 0 ? "drain0" : "drain1", 32'(left), 32'd0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic       saw_busy;
    logic [7:0] d;
    logic       stop;
    logic       pbit;
    int         gap;

    reset  = 1'b1;
    if0.rx = 1'b1;
    if1.rx = 1'b1;
    repeat (5) @(negedge clk);
    check("reset_bps_en0", 32'(if0.bps_en), 32'd0);
    check("reset_busy0", 32'(if0.busy), 32'd0);
    check("reset_rx_valid0", 32'(if0.rx_valid), 32'd0);
    check("reset_rx_data0", 32'(if0.rx_data), 32'd0);
    check("reset_frame_err0", 32'(if0.frame_err), 32'd0);
    check("reset_parity_err1", 32'(if1.parity_err), 32'd0);
    reset = 1'b0;
    repeat (10) @(negedge clk);

    // Clean 0xA5 frame.
    send_frame(0, 8'hA5, 1'b1, 1'b0, BIT);
    wait_drain(0);
    check("a5_busy_after", 32'(if0.busy), 32'd0);
    check("a5_bps_en_after", 32'(if0.bps_en), 32'd0);

    // False start: short low glitch.
    hold(0, 1'b0, 10);
    set_rx(0, 1'b1);
    saw_busy = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (if0.busy) saw_busy = 1'b1;
    end
    check("false_start_entered", 32'(saw_busy), 32'd1);
    check("false_start_busy", 32'(if0.busy), 32'd0);
    check("false_start_bps_en", 32'(if0.bps_en), 32'd0);
    hold(0, 1'b1, BIT);

    // 0x3C with stop=0 and line held low for three bit times.
    push_exp(0, 8'h3C, 1'b0, 1'b0);
    hold(0, 1'b0, BIT);
    for (int i = 0; i < 8; i++) begin
      d = 8'h3C;
      hold(0, d[i], BIT);
    end
    hold(0, 1'b0, 3 * BIT);
    check("break_no_retrigger", 32'(if0.busy), 32'd0);
    hold(0, 1'b1, 2 * BIT);
    check("break_idle_high", 32'(if0.busy), 32'd0);
    wait_drain(0);

    // Even parity on the parity instance.
    send_frame(1, 8'h07, 1'b1, 1'b1, BIT);
    send_frame(1, 8'h07, 1'b1, 1'b0, BIT);
    wait_drain(1);

    // Async reset during bit 4 of 0x81.
    d = 8'h81;
    hold(0, 1'b0, BIT);
    for (int i = 0; i < 4; i++) hold(0, d[i], BIT);
    hold(0, d[4], 60);
    #3 reset = 1'b1;
    #1;
    check("mid_reset_busy0", 32'(if0.busy), 32'd0);
    check("mid_reset_bps_en0", 32'(if0.bps_en), 32'd0);
    check("mid_reset_rx_valid0", 32'(if0.rx_valid), 32'd0);
    check("mid_reset_rx_data0", 32'(if0.rx_data), 32'd0);
    check("mid_reset_rx_data1", 32'(if1.rx_data), 32'd0);
    if0.rx = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    hold(0, 1'b1, BIT);
    send_frame(0, 8'h5A, 1'b1, 1'b0, BIT);

    // Back-to-back frames, no idle between.
    send_frame(0, 8'h00, 1'b1, 1'b0, 0);
    send_frame(0, 8'hFF, 1'b1, 1'b0, BIT);
    wait_drain(0);

    // Randomized frames on both instances.
    for (int n = 0; n < 20; n++) begin
      d    = 8'($urandom_range(0, 255));
      stop = ($urandom_range(0, 3) != 0);
      gap  = $urandom_range(0, 150);
      if (!stop && gap < 20) gap = 20;
      send_frame(0, d, stop, 1'b0, gap);
    end
    for (int n = 0; n < 12; n++) begin
      d    = 8'($urandom_range(0, 255));
      pbit = 1'($urandom_range(0, 1));
      gap  = $urandom_range(0, 100);
      send_frame(1, d, 1'b1, pbit, gap);
    end
    hold(0, 1'b1, BIT);
    wait_drain(0);
    wait_drain(1);
    check("final_busy0", 32'(if0.busy), 32'd0);
    check("final_busy1", 32'(if1.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1500000;
    $display("FAIL watchdog actual=timeout required=finish checks=%0d failures=%0d", n_checks, n_fail);
    $fatal(1, "watchdog expired");
  end

endmodule
